// File: rtl/sm_pwr_pkg.sv
// Shared SM power-management definitions.
// Holds the 2-bit DVFS level type and its named values (also used by the SM power manager),
// the transition sequencer FSM state encoding, and the level -> regulator code lookup.
package sm_pwr_pkg;

  localparam int unsigned VCODE_W = 8;

  typedef logic [1:0] level_t;

  localparam level_t LVL_OFF  = 2'b00;
  localparam level_t LVL_LOW  = 2'b01;
  localparam level_t LVL_MED  = 2'b10;
  localparam level_t LVL_HIGH = 2'b11;

  localparam logic [VCODE_W-1:0] VCODE_L0 = 8'h00;
  localparam logic [VCODE_W-1:0] VCODE_L1 = 8'h40;
  localparam logic [VCODE_W-1:0] VCODE_L2 = 8'h60;
  localparam logic [VCODE_W-1:0] VCODE_L3 = 8'h80;

  typedef enum logic [2:0] {
    StIdle,
    StVReq,
    StVSettle,
    StFReq,
    StFWait,
    StDone
  } dvfs_state_e;

  function automatic logic [VCODE_W-1:0] level_to_vcode(input level_t lvl);
    logic [VCODE_W-1:0] code;
    case (lvl)
      LVL_OFF: code = VCODE_L0;
      LVL_LOW: code = VCODE_L1;
      LVL_MED: code = VCODE_L2;
      default: code = VCODE_L3;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/dvfs_transition_sequencer.sv
// DVFS transition sequencer for one SM.
// Filters the requested level for stability, then moves the SM power/clock domain to it:
// raising goes voltage first then frequency, lowering goes frequency first then voltage.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   i_req_level           requested level from the power manager
//   i_req_clk_en          clock-enable request from the power manager
//   o_vreg_code           regulator target code, o_vreg_valid / i_vreg_ready handshake
//   o_freq_sel            clock generator select, o_freq_req pulse / i_freq_done pulse
//   o_cur_level           committed operating level
//   o_busy                transition in progress
//   o_sm_clk_en           registered SM clock enable
//   o_err_timeout         sticky frequency-lock timeout, cleared by i_err_clr
module dvfs_transition_sequencer
  import sm_pwr_pkg::*;
#(
  parameter int unsigned STABLE_CYC   = 16,
  parameter int unsigned V_SETTLE_CYC = 64,
  parameter int unsigned LOCK_TIMEOUT = 1024,
  parameter int unsigned CNT_W        = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         i_req_level,
  input  logic               i_req_clk_en,
  output logic [VCODE_W-1:0] o_vreg_code,
  output logic               o_vreg_valid,
  input  logic               i_vreg_ready,
  output logic [1:0]         o_freq_sel,
  output logic               o_freq_req,
  input  logic               i_freq_done,
  output logic [1:0]         o_cur_level,
  output logic               o_busy,
  output logic               o_sm_clk_en,
  output logic               o_err_timeout,
  input  logic               i_err_clr
);

  localparam logic [CNT_W-1:0] L_STABLE_LAST = CNT_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] L_SETTLE_LAST = CNT_W'(V_SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] L_LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);

  dvfs_state_e        r_state;
  logic [CNT_W-1:0]   r_cnt;
  level_t             r_prev_req;
  level_t             r_tgt;
  level_t             r_cur_level;
  level_t             r_freq_sel;
  logic [VCODE_W-1:0] r_vreg_code;
  logic               r_vreg_valid;
  logic               r_freq_req;
  logic               r_busy;
  logic               r_sm_clk_en;
  logic               r_err;

  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_req_unstable;
  logic               w_start;
  logic               w_req_up;
  logic               w_tgt_up;

  // Shared counter saturates instead of wrapping.
  assign w_cnt_inc      = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  // A new sample restarts the filter; asking for the current level is not a request.
  assign w_req_unstable = (i_req_level != r_prev_req) || (i_req_level == r_cur_level);
  // Fires on the STABLE_CYC-th equal sample (the first one only clears the counter).
  assign w_start        = (r_state == StIdle) && !w_req_unstable && (w_cnt_inc == L_STABLE_LAST);
  assign w_req_up       = i_req_level > r_cur_level;
  assign w_tgt_up       = r_tgt > r_cur_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_prev_req   <= LVL_HIGH;
      r_tgt        <= LVL_HIGH;
      r_cur_level  <= LVL_HIGH;
      r_freq_sel   <= LVL_HIGH;
      r_vreg_code  <= VCODE_L3;
      r_vreg_valid <= 1'b0;
      r_freq_req   <= 1'b0;
      r_busy       <= 1'b0;
      r_sm_clk_en  <= 1'b1;
      r_err        <= 1'b0;
    end else begin
      r_prev_req  <= i_req_level;
      // w_start keeps the SM running in the first busy cycle as well.
      r_sm_clk_en <= (r_cur_level != LVL_OFF) && (i_req_clk_en || r_busy || w_start);
      if (i_err_clr) begin
        r_err <= 1'b0;
      end

      case (r_state)
        StIdle: begin
          if (w_start) begin
            r_tgt  <= i_req_level;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            if (w_req_up) begin
              r_state      <= StVReq;
              r_vreg_code  <= level_to_vcode(i_req_level);
              r_vreg_valid <= 1'b1;
            end else begin
              r_state    <= StFReq;
              r_freq_sel <= i_req_level;
              r_freq_req <= 1'b1;
            end
          end else if (w_req_unstable) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        StVReq: begin
          if (i_vreg_ready) begin
            r_vreg_valid <= 1'b0;
            r_cnt        <= '0;
            r_state      <= StVSettle;
          end
        end

        StVSettle: begin
          if (r_cnt == L_SETTLE_LAST) begin
            r_cnt <= '0;
            if (w_tgt_up) begin
              r_state    <= StFReq;
              r_freq_sel <= r_tgt;
              r_freq_req <= 1'b1;
            end else begin
              r_state <= StDone;
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        // freq_done is not looked at here, so a pulse coincident with freq_req is dropped.
        StFReq: begin
          r_freq_req <= 1'b0;
          r_cnt      <= '0;
          r_state    <= StFWait;
        end

        StFWait: begin
          if (i_freq_done) begin
            r_cnt <= '0;
            if (w_tgt_up) begin
              r_state <= StDone;
            end else begin
              r_state      <= StVReq;
              r_vreg_code  <= level_to_vcode(r_tgt);
              r_vreg_valid <= 1'b1;
            end
          end else if (r_cnt == L_LOCK_LAST) begin
            // Abandon the transition; a raised voltage is left in place as it is safe.
            r_err      <= 1'b1;
            r_freq_sel <= r_cur_level;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_state    <= StIdle;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        StDone: begin
          r_cur_level <= r_tgt;
          r_cnt       <= '0;
          r_busy      <= 1'b0;
          r_state     <= StIdle;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_vreg_code   = r_vreg_code;
  assign o_vreg_valid  = r_vreg_valid;
  assign o_freq_sel    = r_freq_sel;
  assign o_freq_req    = r_freq_req;
  assign o_cur_level   = r_cur_level;
  assign o_busy        = r_busy;
  assign o_sm_clk_en   = r_sm_clk_en;
  assign o_err_timeout = r_err;

endmodule

// File: tb/tb_dvfs_transition_sequencer.sv
// Scoreboard bench for dvfs_transition_sequencer: the stimulus pushes the expected regulator
// codes, frequency selects and end-of-transition states; a monitor compares them as the DUT
// presents each transfer, freq_req pulse and busy fall.
module tb_dvfs_transition_sequencer;
  import sm_pwr_pkg::*;

  typedef struct packed {
    logic [1:0] lvl;
    logic       err;
  } end_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] i_req_level;
  logic       i_req_clk_en;
  logic [7:0] o_vreg_code;
  logic       o_vreg_valid;
  logic       i_vreg_ready;
  logic [1:0] o_freq_sel;
  logic       o_freq_req;
  logic       i_freq_done;
  logic [1:0] o_cur_level;
  logic       o_busy;
  logic       o_sm_clk_en;
  logic       o_err_timeout;
  logic       i_err_clr;

  dvfs_transition_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req_level  (i_req_level),
    .i_req_clk_en (i_req_clk_en),
    .o_vreg_code  (o_vreg_code),
    .o_vreg_valid (o_vreg_valid),
    .i_vreg_ready (i_vreg_ready),
    .o_freq_sel   (o_freq_sel),
    .o_freq_req   (o_freq_req),
    .i_freq_done  (i_freq_done),
    .o_cur_level  (o_cur_level),
    .o_busy       (o_busy),
    .o_sm_clk_en  (o_sm_clk_en),
    .o_err_timeout(o_err_timeout),
    .i_err_clr    (i_err_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [1:0] q_freq[$];
  logic [7:0] q_vcode[$];
  end_t       q_end[$];

  int ready_delay = 0;
  int done_delay  = 1;   // negative: never answer
  int t_accept = 0, t_freq_req = 0, t_fdone = 0, t_idle = 0;
  int valid_len = 0, n_accept = 0, n_freq_req = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void unexpected(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: event seen, none expected", name);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Regulator model: raises ready ready_delay cycles after valid rises.
  initial begin
    int vcnt;
    vcnt = 0;
    i_vreg_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || !o_vreg_valid) begin
        i_vreg_ready = 1'b0;
        vcnt = 0;
      end else begin
        i_vreg_ready = (vcnt == ready_delay);
        vcnt++;
      end
    end
  end

  // Clock generator model: freq_done pulse done_delay cycles after the freq_req pulse.
  initial begin
    int  fcnt;
    bit  armed;
    fcnt = 0;
    armed = 1'b0;
    i_freq_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      i_freq_done = 1'b0;
      if (!rst_n) begin
        armed = 1'b0;
      end else if (o_freq_req) begin
        armed = 1'b1;
        fcnt = 0;
      end else if (armed) begin
        fcnt++;
        if (done_delay >= 0 && fcnt == done_delay) begin
          i_freq_done = 1'b1;
          armed = 1'b0;
        end
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic prev_busy;
    int   vrun;
    end_t e;
    prev_busy = 1'b0;
    vrun = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_busy = 1'b0;
        vrun = 0;
      end else begin
        if (o_vreg_valid) vrun++;
        if (o_vreg_valid && i_vreg_ready) begin
          valid_len = vrun;
          vrun = 0;
          t_accept = cyc;
          n_accept++;
          if (q_vcode.size() == 0) unexpected("vreg_xfer");
          else check("vreg_code", o_vreg_code, q_vcode.pop_front());
        end
        if (o_freq_req) begin
          t_freq_req = cyc;
          n_freq_req++;
          if (q_freq.size() == 0) unexpected("freq_req");
          else check("freq_sel", o_freq_sel, q_freq.pop_front());
        end
        if (i_freq_done) t_fdone = cyc;
        if (prev_busy && !o_busy) begin
          t_idle = cyc;
          if (q_end.size() == 0) begin
            unexpected("busy_fall");
          end else begin
            e = q_end.pop_front();
            check("end_cur_level", o_cur_level, e.lvl);
            check("end_err_timeout", o_err_timeout, e.err);
          end
        end
        prev_busy = o_busy;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input logic want, input int bound, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < bound && !hit; i++) begin
      @(negedge clk);
      if (o_busy == want) hit = 1'b1;
    end
    if (!hit) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: busy=%0b, want %0b within %0d cycles", name, o_busy, want, bound);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cur_level"}, o_cur_level, 2'b11);
    check({tag, "_freq_sel"}, o_freq_sel, 2'b11);
    check({tag, "_vreg_code"}, o_vreg_code, 8'h80);
    check({tag, "_vreg_valid"}, o_vreg_valid, 1'b0);
    check({tag, "_freq_req"}, o_freq_req, 1'b0);
    check({tag, "_busy"}, o_busy, 1'b0);
    check({tag, "_sm_clk_en"}, o_sm_clk_en, 1'b1);
    check({tag, "_err_timeout"}, o_err_timeout, 1'b0);
  endtask

  initial begin
    bit saw_busy;
    int n0;
    rst_n = 1'b1;
    i_req_level = 2'b11;
    i_req_clk_en = 1'b1;
    i_err_clr = 1'b0;
    #2 rst_n = 1'b0;
    #20;
    check_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Idle at level 11: the clock enable follows the request.
    drive_edge();
    i_req_clk_en = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_clk_en_off", o_sm_clk_en, 1'b0);
    drive_edge();
    i_req_clk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_clk_en_on", o_sm_clk_en, 1'b1);

    // Only 15 equal samples: no transition.
    drive_edge();
    i_req_level = 2'b01;
    repeat (15) drive_edge();
    i_req_level = 2'b11;
    saw_busy = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (o_busy) saw_busy = 1'b1;
    end
    check("filter_15_no_busy", saw_busy, 1'b0);

    // Down path 11 -> 01: frequency first, then voltage.
    ready_delay = 0;
    done_delay = 5;
    q_freq.push_back(2'b01);
    q_vcode.push_back(8'h40);
    q_end.push_back('{lvl: 2'b01, err: 1'b0});
    drive_edge();
    i_req_level = 2'b01;
    repeat (16) @(negedge clk);
    check("filter_busy_cyc16", o_busy, 1'b0);
    @(negedge clk);
    check("filter_busy_cyc17", o_busy, 1'b1);
    check("down_first_freq_req", o_freq_req, 1'b1);
    check("down_first_clk_en", o_sm_clk_en, 1'b1);
    // Requests and clock-enable changes while busy must not disturb the transition.
    drive_edge();
    i_req_clk_en = 1'b0;
    i_req_level = 2'b00;
    repeat (10) @(negedge clk);
    check("mid_xfer_clk_en", o_sm_clk_en, 1'b1);
    drive_edge();
    i_req_level = 2'b01;
    repeat (30) @(negedge clk);
    check("mid_xfer_clk_en_late", o_sm_clk_en, 1'b1);
    wait_busy(1'b0, 200, "down_idle");
    check("down_vreg_after_fdone", t_accept > t_fdone, 1'b1);
    repeat (3) @(negedge clk);
    check("idle_01_clk_en_off", o_sm_clk_en, 1'b0);
    drive_edge();
    i_req_clk_en = 1'b1;

    // Up path 01 -> 10 with no freq_done: lock timeout.
    ready_delay = 0;
    done_delay = -1;
    q_vcode.push_back(8'h60);
    q_freq.push_back(2'b10);
    q_end.push_back('{lvl: 2'b01, err: 1'b1});
    drive_edge();
    i_req_level = 2'b10;
    wait_busy(1'b1, 40, "timeout_start");
    drive_edge();
    i_req_level = 2'b01;
    wait_busy(1'b0, 1300, "timeout_idle");
    check("timeout_fwait_len", t_idle - t_freq_req, 1025);
    check("timeout_freq_sel", o_freq_sel, 2'b01);
    check("timeout_cur_level", o_cur_level, 2'b01);
    check("timeout_vreg_code", o_vreg_code, 8'h60);
    check("timeout_err", o_err_timeout, 1'b1);
    drive_edge();
    i_err_clr = 1'b1;
    drive_edge();
    i_err_clr = 1'b0;
    @(negedge clk);
    check("err_clr", o_err_timeout, 1'b0);

    // Up path 01 -> 10 with a slow regulator.
    ready_delay = 3;
    done_delay = 2;
    q_vcode.push_back(8'h60);
    q_freq.push_back(2'b10);
    q_end.push_back('{lvl: 2'b10, err: 1'b0});
    drive_edge();
    i_req_level = 2'b10;
    wait_busy(1'b1, 40, "up_start");
    wait_busy(1'b0, 200, "up_idle");
    check("up_valid_len", valid_len, 4);
    check("up_settle_before_freq", (t_freq_req - t_accept) >= 65, 1'b1);

    // Down to off: clock gated even with the enable requested.
    ready_delay = 0;
    done_delay = 1;
    q_freq.push_back(2'b00);
    q_vcode.push_back(8'h00);
    q_end.push_back('{lvl: 2'b00, err: 1'b0});
    drive_edge();
    i_req_level = 2'b00;
    wait_busy(1'b1, 40, "off_start");
    wait_busy(1'b0, 200, "off_idle");
    repeat (3) @(negedge clk);
    check("off_clk_en", o_sm_clk_en, 1'b0);

    // Reset during V_SETTLE of 00 -> 11.
    q_vcode.push_back(8'h80);
    n0 = n_accept;
    drive_edge();
    i_req_level = 2'b11;
    for (int i = 0; i < 60 && n_accept == n0; i++) @(negedge clk);
    check("rst_mid_accept_seen", n_accept, n0 + 1);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset("rst_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n0 = n_freq_req;
    saw_busy = 1'b0;
    repeat (150) begin
      @(negedge clk);
      if (o_busy) saw_busy = 1'b1;
    end
    check("rst_mid_no_freq_req", n_freq_req, n0);
    check("rst_mid_no_busy", saw_busy, 1'b0);

    check("q_freq_empty", q_freq.size(), 0);
    check("q_vcode_empty", q_vcode.size(), 0);
    check("q_end_empty", q_end.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dvfs_transition_sequencer.md
Name: dvfs_transition_sequencer

Overview:
- Consumer side of the per-SM power-management interface: takes the requested DVFS level and clock-enable request from the SM power manager.
- Filters the level request for stability, then performs safe voltage/frequency transitions.
  - Raising: voltage first, then frequency.
  - Lowering: frequency first, then voltage.
- Handshakes with the voltage regulator (valid/ready) and the clock generator (request/done pulse).
- Drives the final SM clock enable. Sits between the SM power manager and the SM power/clock domain.

Parameters:
STABLE_CYC, 16, consecutive cycles req_level must hold a new value before a transition starts
V_SETTLE_CYC, 64, cycles waited after regulator accepts a code
LOCK_TIMEOUT, 1024, max cycles waiting for freq_done
CNT_W, 12, width of the shared cycle counter; must hold max(STABLE_CYC, V_SETTLE_CYC, LOCK_TIMEOUT)
VCODE_W, 8, regulator code width
VCODE_L0/L1/L2/L3, 8'h00/8'h40/8'h60/8'h80, regulator code for level off/low/med/high

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
req_level  in  2  requested level (00 off, 01 low, 10 med, 11 high)
req_clk_en  in  1  clock-enable request from power manager (1 = run)
vreg_code  out  VCODE_W  regulator target code
vreg_valid  out  1  code valid to regulator
vreg_ready  in  1  regulator accepts code (transfer when valid&ready)
freq_sel  out  2  clock generator frequency select (same encoding as level)
freq_req  out  1  one-cycle pulse: apply freq_sel
freq_done  in  1  one-cycle pulse: new frequency locked
cur_level  out  2  committed operating level
busy  out  1  transition in progress (FSM not IDLE)
sm_clk_en  out  1  registered SM clock enable
err_timeout  out  1  sticky: freq_done not received in LOCK_TIMEOUT
err_clr  in  1  clears err_timeout

Behaviour:
- Reset values: cur_level=11, freq_sel=11, vreg_code=VCODE_L3, vreg_valid=0, freq_req=0, busy=0, sm_clk_en=1, err_timeout=0. FSM=IDLE, counter=0.
- Reset asserted mid-transition aborts immediately to the reset values; no handshake completion is required.
- FSM states: IDLE, V_REQ, V_SETTLE, F_REQ, F_WAIT, DONE.
- Stability filter (IDLE only):
  - Counter clears when req_level differs from its previous-cycle value, or equals cur_level.
  - Otherwise the counter increments.
  - When it reaches STABLE_CYC-1, latch tgt=req_level and leave IDLE next cycle. The transition starts after STABLE_CYC equal samples.
- Path selection:
  - Up path (tgt>cur_level): V_REQ → V_SETTLE → F_REQ → F_WAIT → DONE.
  - Down path (tgt<cur_level): F_REQ → F_WAIT → V_REQ → V_SETTLE → DONE.
- V_REQ:
  - vreg_code=VCODE[tgt], vreg_valid=1.
  - vreg_code is stable while valid; vreg_valid is held until the cycle with vreg_ready=1.
  - vreg_valid drops the cycle after the transfer. No timeout.
- V_SETTLE: count V_SETTLE_CYC cycles, then advance.
- F_REQ: freq_sel=tgt; freq_req=1 for exactly one cycle; counter cleared.
- F_WAIT:
  - On freq_done, advance.
  - freq_done arriving in the same cycle as freq_req is ignored.
  - If the counter reaches LOCK_TIMEOUT-1 without freq_done:
    - set err_timeout;
    - restore freq_sel=cur_level;
    - return to IDLE without updating cur_level.
  - On the up path, vreg_code stays at the raised (safe) value; the next transition re-issues the code.
- DONE: cur_level=tgt, then IDLE next cycle. busy=0 from IDLE entry.
- req_level changes while busy are ignored; the filter counter is held at 0 while busy and restarts in IDLE.
- sm_clk_en (registered) = (cur_level!=00) & (req_clk_en | busy).
  - The SM is never gated mid-transition.
  - Level 00 always gates.
- err_timeout: err_clr clears it; a same-cycle set wins over clear.
- Widths: the level comparison is unsigned 2-bit; the counter saturates, never wraps.

Decomposition:
- Shared package sm_pwr_pkg holds:
  - the 2-bit level typedef and the LVL_OFF/LOW/MED/HIGH constants (shared with the power manager);
  - the FSM state enum;
  - the level→VCODE lookup function.
- No sub-module: the single shared counter serves the filter, settle and timeout phases.

Test Plan:
- Stability filter: from reset, hold req_level=01 for 15 cycles then 11 → no transition, busy stays 0. Hold 01 for 16 cycles → busy=1 on cycle 17; down path starts with freq_req pulse, freq_sel=01.
- Down path: 11→01, freq_done 5 cycles after freq_req, vreg_ready immediate → vreg_code=8'h40 issued only after freq_done; cur_level=01 after 64 settle cycles + DONE.
- Up path: 01→10 with vreg_ready delayed 3 cycles → vreg_valid held 4 cycles with code 8'h60; freq_req no earlier than 64 cycles after the accept; cur_level=10.
- Timeout: up path, freq_done never asserted → err_timeout=1 after 1024 cycles in F_WAIT, freq_sel restored to 01, cur_level stays 01, vreg_code stays 8'h60; err_clr → err_timeout=0.
- Off and gating:
  - req_level=00 → after transition cur_level=00, sm_clk_en=0 regardless of req_clk_en.
  - At level 11 with req_clk_en=0 and idle → sm_clk_en=0; toggling req_clk_en mid-transition keeps sm_clk_en=1.
- Reset mid-V_SETTLE: assert rst_n=0 → all outputs return to reset values asynchronously; no freq_req after release until a new stable request.
